// File: rtl/maj_tt_sweeper.sv
// maj_tt_sweeper: programmable majority-gate network truth-table generator with valid/ready word streaming
module maj_tt_sweeper #(
    parameter int N_IN = 7,
    parameter int N_GATES = 6,
    parameter int OUT_W = 32,
    localparam int SEL_W = $clog2(1 + N_IN + N_GATES),
    localparam int FW = SEL_W + 1,
    localparam int AW = $clog2(N_GATES + 1),
    localparam int LW = $clog2(OUT_W),
    localparam int IW = (N_IN - LW) < 1 ? 1 : N_IN - LW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [3*FW-1:0]   cfg_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [IW-1:0]     out_index,
    output logic              out_last
);
    typedef enum logic [1:0] {IDLE, RUN, EMIT} state_t;
    state_t state;
    logic [3*FW-1:0] gate_cfg [N_GATES];
    logic [FW-1:0] out_cfg;
    logic [N_IN-1:0] cnt;
    logic [OUT_W-1:0] pack, pack_nxt;
    logic f;
    // gates are evaluated in order, so w bits at or above the current gate are still zero when it reads them
    function automatic logic eval_f(input logic [N_IN-1:0] x);
        logic [N_GATES-1:0] w;
        logic [2**SEL_W-1:0] s;
        logic [2:0] op;
        w = '0;
        for (int k = 0; k < N_GATES; k++) begin
            s = '0;
            s[N_IN:1] = x;
            s[N_IN+N_GATES:N_IN+1] = w;
            for (int o = 0; o < 3; o++) op[o] = s[gate_cfg[k][o*FW +: SEL_W]] ^ gate_cfg[k][o*FW+SEL_W];
            w[k] = (op[0] & op[1]) | (op[0] & op[2]) | (op[1] & op[2]);
        end
        s = '0;
        s[N_IN:1] = x;
        s[N_IN+N_GATES:N_IN+1] = w;
        return s[out_cfg[SEL_W-1:0]] ^ out_cfg[SEL_W];
    endfunction
    // network output for the current minterm merged into the word being packed
    always_comb begin
        f = eval_f(cnt);
        pack_nxt = pack;
        pack_nxt[cnt[LW-1:0]] = f;
    end
    // configuration registers, writable only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_GATES; k++) gate_cfg[k] <= '0;
            out_cfg <= '0;
        end else if (cfg_we && !busy) begin
            for (int k = 0; k < N_GATES; k++) if (cfg_addr == AW'(k)) gate_cfg[k] <= cfg_data;
            if (cfg_addr == AW'(N_GATES)) out_cfg <= cfg_data[FW-1:0];
        end
    end
    // sweep controller: one minterm per RUN cycle, one EMIT hold per word
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            pack <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_index <= '0;
            out_last <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    busy <= 1'b1;
                    cnt <= '0;
                end
                RUN: begin
                    pack <= pack_nxt;
                    cnt <= cnt + 1'b1;
                    if (&cnt[LW-1:0]) begin
                        state <= EMIT;
                        out_valid <= 1'b1;
                        out_data <= pack_nxt;
                        out_index <= IW'(cnt >> LW);
                        out_last <= &cnt;
                    end
                end
                EMIT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state <= out_last ? IDLE : RUN;
                    busy <= !out_last;
                    done <= out_last;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maj_tt_sweeper.sv
// tb_maj_tt_sweeper: directed table-driven bench for the majority-network truth-table sweeper
module tb_maj_tt_sweeper;
    logic clk = 1'b0, rst = 1'b1, cfg_we = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [14:0] cfg_data = '0;
    logic busy, done, out_valid, out_last;
    logic [31:0] out_data;
    logic [1:0] out_index;
    int ncmp = 0, nfail = 0;

    always #5 clk = ~clk;

    maj_tt_sweeper dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last)
    );

    typedef struct {
        logic [14:0] g0;
        logic [14:0] g1;
        logic [4:0] oc;
        logic [3:0][31:0] w;
    } vec_t;
    vec_t tv [8];

    function automatic logic [14:0] g(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return {c, b, a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] a, input logic [14:0] d);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " busy"}, 32'(busy), 0);
        chk({nm, " done"}, 32'(done), 0);
        chk({nm, " valid"}, 32'(out_valid), 0);
        chk({nm, " data"}, out_data, 0);
        chk({nm, " index"}, 32'(out_index), 0);
        chk({nm, " last"}, 32'(out_last), 0);
    endtask

    // rnd: random out_ready; inj: stray start and cfg write mid-sweep; co: cfg write alongside start
    task automatic sweep(input string nm, input logic [3:0][31:0] ex, input bit rnd, input bit inj,
                         input bit co, input logic [14:0] cd);
        int e = -1;
        int got = 0;
        bit seen = 0;
        @(negedge clk);
        start = 1'b1;
        cfg_we = co;
        cfg_addr = 3'd6;
        cfg_data = cd;
        while (got < 4 && e < 3000) begin
            @(negedge clk);
            e++;
            start = inj && e == 5;
            cfg_we = inj && e == 10;
            if (inj && e == 10) begin
                cfg_addr = 3'd6;
                cfg_data = 15'h10;
            end
            if (e == 0) chk({nm, " busy after start"}, 32'(busy), 1);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (!rnd && !seen && got == 0) chk({nm, " first valid cycle"}, e, 32);
                seen = 1;
                chk($sformatf("%s word%0d data", nm, got), out_data, ex[got]);
                chk($sformatf("%s word%0d index", nm, got), 32'(out_index), got);
                chk($sformatf("%s word%0d last", nm, got), 32'(out_last), 32'(got == 3));
                if (out_ready) begin
                    got++;
                    seen = 0;
                end
            end
        end
        chk({nm, " words received"}, got, 4);
        start = 1'b0;
        cfg_we = 1'b0;
        @(negedge clk);
        e++;
        chk({nm, " done pulse"}, 32'(done), 1);
        chk({nm, " busy at done"}, 32'(busy), 0);
        if (!rnd) chk({nm, " done cycle"}, e, 132);
        @(negedge clk);
        chk({nm, " done cleared"}, 32'(done), 0);
    endtask

    initial begin
        int n;
        tv[0] = '{g(5'd1, 5'd2, 5'd3), 15'd0, 5'd8, {4{32'hE8E8E8E8}}};
        tv[1] = '{g(5'd1, 5'd2, 5'd0), 15'd0, 5'd8, {4{32'h88888888}}};
        tv[2] = '{g(5'd1, 5'd2, 5'd0), 15'd0, 5'h18, {4{32'h77777777}}};
        tv[3] = '{g(5'd1, 5'd2, 5'd3), g(5'h18, 5'd4, 5'd0), 5'd9, {4{32'h17001700}}};
        tv[4] = '{g(5'd1, 5'd9, 5'd2), g(5'h10, 5'h10, 5'd0), 5'd8, {4{32'h88888888}}};
        tv[5] = '{15'd0, 15'd0, 5'h0F, {4{32'h00000000}}};
        tv[6] = '{15'd0, 15'd0, 5'h10, {4{32'hFFFFFFFF}}};
        tv[7] = '{15'd0, 15'd0, 5'd7, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0}};
        repeat (3) @(negedge clk);
        chk_zero("in reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("after reset");
        sweep("unconfigured", {4{32'h0}}, 0, 0, 0, 15'd0);
        for (int i = 0; i < 8; i++) begin
            cfg(3'd0, tv[i].g0);
            cfg(3'd1, tv[i].g1);
            cfg(3'd6, {10'd0, tv[i].oc});
            sweep($sformatf("vec%0d", i), tv[i].w, 0, 0, 0, 15'd0);
        end
        cfg(3'd7, 15'h10);
        sweep("x6 random ready", tv[7].w, 1, 0, 0, 15'd0);
        sweep("x6 stray start/cfg", tv[7].w, 0, 1, 0, 15'd0);
        sweep("x6 old config kept", tv[7].w, 0, 0, 0, 15'd0);
        sweep("cfg with start", {4{32'hFFFFFFFF}}, 0, 0, 1, 15'h10);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        out_ready = 1'b1;
        while (!(out_valid && out_index == 2'd1) && n < 500) begin
            @(negedge clk);
            n++;
            out_ready = !(out_valid && out_index == 2'd1);
        end
        chk("reach word1 emit", 32'(n < 500), 1);
        chk("word1 before reset", out_data, 32'hFFFFFFFF);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("reset in emit");
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk_zero("after emit reset");
        sweep("config cleared", {4{32'h0}}, 0, 0, 0, 15'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
